// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bundle of the async FIFO: read request, synchronised write pointer, and the read-domain status outputs.
// When FIFO_RD_UFLOW_EN is defined, the bundle also carries the sticky underflow flag rUFLOW.
interface fifo_rd_ctrl_if #(
  parameter int unsigned ADDRSIZE = 4
);
  localparam int unsigned PW = ADDRSIZE + 1;

  logic          rINC;
  logic [PW-1:0] rq2_wptr;
  logic [ADDRSIZE-1:0] rADDR;
  logic [PW-1:0] rPTR;
  logic          rEMPTY;
  logic          rAEMPTY;
  logic [PW-1:0] rLEVEL;
`ifdef FIFO_RD_UFLOW_EN
  logic          rUFLOW;

  modport master (
    output rINC, rq2_wptr,
    input  rADDR, rPTR, rEMPTY, rAEMPTY, rLEVEL, rUFLOW
  );
  modport slave (
    input  rINC, rq2_wptr,
    output rADDR, rPTR, rEMPTY, rAEMPTY, rLEVEL, rUFLOW
  );
`else
  modport master (
    output rINC, rq2_wptr,
    input  rADDR, rPTR, rEMPTY, rAEMPTY, rLEVEL
  );
  modport slave (
    input  rINC, rq2_wptr,
    output rADDR, rPTR, rEMPTY, rAEMPTY, rLEVEL
  );
`endif
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-pointer controller: binary/Gray read pointers, RAM read address, empty, almost-empty and level.
// Optional sticky underflow flag rUFLOW is built when FIFO_RD_UFLOW_EN is defined.
module fifo_rd_ctrl #(
  parameter int unsigned ADDRSIZE      = 4,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic           rCLK,
  input  logic           rRST,
  fifo_rd_ctrl_if.slave  bus
);
  localparam int unsigned PW = ADDRSIZE + 1;

  logic [PW-1:0] r_bin;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_level;
  logic          r_empty;
  logic          r_aempty;

  logic          w_ren;
  logic [PW-1:0] w_bin_nx;
  logic [PW-1:0] w_gray_nx;
  logic [PW-1:0] w_wbin;
  logic [PW-1:0] w_level_nx;

  assign w_ren      = bus.rINC & ~r_empty;
  assign w_bin_nx   = r_bin + PW'(w_ren);
  assign w_gray_nx  = (w_bin_nx >> 1) ^ w_bin_nx;
  assign w_level_nx = w_wbin - w_bin_nx;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_wbin = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      w_wbin = w_wbin ^ (bus.rq2_wptr >> i);
    end
  end

  // Flags come from the next pointer so they move on the same edge as the pointer.
  always_ff @(posedge rCLK or negedge rRST) begin
    if (!rRST) begin
      r_bin    <= '0;
      r_ptr    <= '0;
      r_empty  <= 1'b1;
      r_aempty <= 1'b1;
      r_level  <= '0;
    end else begin
      r_bin    <= w_bin_nx;
      r_ptr    <= w_gray_nx;
      r_empty  <= (w_gray_nx == bus.rq2_wptr);
      r_aempty <= (w_level_nx <= PW'(AEMPTY_THRESH));
      r_level  <= w_level_nx;
    end
  end

  assign bus.rADDR   = r_bin[ADDRSIZE-1:0];
  assign bus.rPTR    = r_ptr;
  assign bus.rEMPTY  = r_empty;
  assign bus.rAEMPTY = r_aempty;
  assign bus.rLEVEL  = r_level;

`ifdef FIFO_RD_UFLOW_EN
  logic r_uflow;

  // Sticky until reset: any read request while empty.
  always_ff @(posedge rCLK or negedge rRST) begin
    if (!rRST) begin
      r_uflow <= 1'b0;
    end else if (bus.rINC & r_empty) begin
      r_uflow <= 1'b1;
    end
  end

  assign bus.rUFLOW = r_uflow;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: a word-count model predicts each cycle's outputs, and a monitor compares them.
// Honours FIFO_RD_UFLOW_EN when it is defined for the build.
module tb_fifo_rd_ctrl;
  localparam int unsigned AW    = 4;
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned TH    = 2;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_rd_ctrl_if #(.ADDRSIZE(AW)) bus ();

  fifo_rd_ctrl #(.ADDRSIZE(AW), .AEMPTY_THRESH(TH)) dut (
    .rCLK (clk),
    .rRST (rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [PW-1:0] level;
    logic [PW-1:0] ptr;
    logic [AW-1:0] addr;
    logic          empty;
    logic          aempty;
    logic          uflow;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Model state: total words read, and total words the read side has been shown.
  int unsigned rd_cnt   = 0;
  int unsigned prev_vis = 0;
  logic        m_uflow  = 1'b0;

  function automatic logic [PW-1:0] gray(input int unsigned v);
    logic [PW-1:0] b;
    b = PW'(v % (2 * DEPTH));
    return (b >> 1) ^ b;
  endfunction

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One read-clock cycle: wv is the total write count visible through the synchroniser.
  task automatic step(input logic inc, input int unsigned wv);
    bit   cur_empty;
    exp_t e;
    @(negedge clk);
    bus.rINC     = inc;
    bus.rq2_wptr = gray(wv);
    cur_empty = (prev_vis == rd_cnt);
    if (inc && cur_empty) m_uflow = 1'b1;
    if (inc && !cur_empty) rd_cnt++;
    e.level  = PW'(wv - rd_cnt);
    e.empty  = (wv == rd_cnt);
    e.aempty = ((wv - rd_cnt) <= TH);
    e.addr   = AW'(rd_cnt % DEPTH);
    e.ptr    = gray(rd_cnt);
    e.uflow  = m_uflow;
    q.push_back(e);
    prev_vis = wv;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ptr"},    32'(bus.rPTR),    0);
    chk({tag, "_addr"},   32'(bus.rADDR),   0);
    chk({tag, "_empty"},  32'(bus.rEMPTY),  1);
    chk({tag, "_aempty"}, 32'(bus.rAEMPTY), 1);
    chk({tag, "_level"},  32'(bus.rLEVEL),  0);
`ifdef FIFO_RD_UFLOW_EN
    chk({tag, "_uflow"},  32'(bus.rUFLOW),  0);
`endif
  endtask

  // Asynchronous reset asserted between edges with a read request pending.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n    = 1'b0;
    bus.rINC = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    rd_cnt       = 0;
    prev_vis     = 0;
    m_uflow      = 1'b0;
    bus.rq2_wptr = '0;
    repeat (2) @(negedge clk);
    bus.rINC = 1'b0;
    rst_n    = 1'b1;
  endtask

  // Monitor: every cycle after a stimulus push, the registered outputs must match.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        chk("level",  32'(bus.rLEVEL),  32'(e.level));
        chk("empty",  32'(bus.rEMPTY),  32'(e.empty));
        chk("aempty", 32'(bus.rAEMPTY), 32'(e.aempty));
        chk("addr",   32'(bus.rADDR),   32'(e.addr));
        chk("ptr",    32'(bus.rPTR),    32'(e.ptr));
`ifdef FIFO_RD_UFLOW_EN
        chk("uflow",  32'(bus.rUFLOW),  32'(e.uflow));
`endif
      end
    end
  end

  initial begin
    int unsigned wv;
    rst_n        = 1'b0;
    bus.rINC     = 1'b0;
    bus.rq2_wptr = '0;
    #12;
    chk_reset_vals("power_on");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill view, drain to empty, then one read attempt while empty.
    step(1'b0, 4);
    repeat (4) step(1'b1, 4);
    step(1'b1, 4);
    step(1'b0, 6);
    step(1'b1, 6);
    do_reset();

    // Full view from a reset pointer, drained completely plus one extra request.
    step(1'b0, 16);
    repeat (17) step(1'b1, 16);
    do_reset();

    // Streaming 40 words, one write per cycle, reading continuously.
    wv = 0;
    for (int i = 0; i < 50; i++) begin
      if (wv < 40 && wv - rd_cnt < DEPTH) wv++;
      step(1'b1, wv);
    end

    // Random traffic: write bursts bounded by depth, reads with varying duty.
    for (int i = 0; i < 1500; i++) begin
      int unsigned add;
      logic        inc;
      add = $urandom_range(0, 2);
      if (wv + add - rd_cnt > DEPTH) add = DEPTH - (wv - rd_cnt);
      wv += add;
      inc = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step(inc, wv);
    end

    do_reset();
    step(1'b0, 3);
    repeat (5) step(1'b1, 3);

    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
